// File: rtl/approx_pkg.sv
// Shared constants and mode encoding for the lower-part-OR approximate adder pipeline.
package approx_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LPP   = 2;
  localparam int DEF_ET    = 0;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/approx_adder_core.sv
// Combinational datapath: exact sum, lower-part-OR approximate sum, mode select and |error|.
module approx_adder_core
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LPP   = DEF_LPP
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   err
);

  logic [WIDTH:0] approx;

  assign exact = {1'b0, a} + {1'b0, b};

  generate
    if (LPP == 0) begin : g_no_lpp
      assign approx = exact;
    end else begin : g_lpp
      logic                 carry;
      logic [WIDTH-LPP:0]   upper;
      // Low bits are OR-ed; only the top low bit pair feeds a carry upward.
      assign carry = a[LPP-1] & b[LPP-1];
      assign upper = {1'b0, a[WIDTH-1:LPP]} + {1'b0, b[WIDTH-1:LPP]}
                   + {{(WIDTH-LPP){1'b0}}, carry};
      assign approx = {upper, a[LPP-1:0] | b[LPP-1:0]};
    end
  endgenerate

  assign sum = (mode_e'(mode) == MODE_APPROX) ? approx : exact;
  assign err = (exact >= sum) ? (exact - sum) : (sum - exact);

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready pipeline around approx_adder_core with error statistics on output transfer.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int             WIDTH = DEF_WIDTH,
  parameter int             LPP   = DEF_LPP,
  parameter logic [WIDTH:0] ET    = (WIDTH+1)'(DEF_ET),
  parameter int             CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clr,
  output logic [WIDTH:0]   max_err,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             viol
);

  logic [2:1]       vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_mode;
  logic [WIDTH:0]   core_sum, core_exact, core_err, s2_exact;
  logic             s1_adv, s2_adv, out_fire;

  assign s2_adv    = !vld_pipe[2] | out_ready;
  assign s1_adv    = !vld_pipe[1] | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];
  assign out_fire  = vld_pipe[2] & out_ready;

  approx_adder_core #(.WIDTH(WIDTH), .LPP(LPP)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .mode  (s1_mode),
    .sum   (core_sum),
    .exact (core_exact),
    .err   (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
      out_sum  <= '0;
      out_err  <= '0;
      s2_exact <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_a    <= in_a;
          s1_b    <= in_b;
          s1_mode <= in_mode;
        end
      end
      // Stage 2 only loads when it can move, so a stalled result stays put.
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_sum  <= core_sum;
          s2_exact <= core_exact;
          out_err  <= core_err;
        end
      end
    end
  end

  // Clear beats a coincident transfer: that beat is simply not accounted.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      max_err  <= '0;
      viol_cnt <= '0;
      viol     <= 1'b0;
    end else if (out_fire) begin
      if (out_err > max_err) max_err <= out_err;
      if (out_err > ET) begin
        viol <= 1'b1;
        if (viol_cnt != '1) viol_cnt <= viol_cnt + 1'b1;
      end
    end
  end

  // The registered error must always agree with the registered exact/selected pair.
  always_ff @(posedge clk) begin
    if (!rst && vld_pipe[2])
      assert (out_err == ((s2_exact >= out_sum) ? (s2_exact - out_sum) : (out_sum - s2_exact)));
  end

endmodule
